// File: rtl/cotm32_pkg.sv
// Core-wide constants shared by the cotm32 datapath blocks.
package cotm32_pkg;
    localparam int XLEN     = 32;
    localparam int NUM_REGS = 32;
endpackage

// File: rtl/register_file_mp.sv
// Multi-ported integer register file with optional write-to-read bypass and busy scoreboard.
// x0 is hardwired to zero and never busy; higher write-port index wins on address clash.
module register_file_mp
    import cotm32_pkg::*;
#(
    parameter int N_RPORTS = 2,
    parameter int N_WPORTS = 1,
    parameter int N_REGS   = NUM_REGS,
    parameter int BYPASS   = 1
) (
    input  logic                                     i_clk,
    input  logic                                     i_rst,
    input  logic [N_WPORTS-1:0]                      i_we,
    input  logic [N_WPORTS-1:0][$clog2(N_REGS)-1:0]  i_waddr,
    input  logic [N_WPORTS-1:0][XLEN-1:0]            i_wdata,
    input  logic                                     i_claim,
    input  logic [$clog2(N_REGS)-1:0]                i_claim_addr,
    input  logic [N_RPORTS-1:0][$clog2(N_REGS)-1:0]  i_raddr,
    output logic [N_RPORTS-1:0][XLEN-1:0]            o_rdata,
    output logic [N_RPORTS-1:0]                      o_busy
);
    localparam int AW = $clog2(N_REGS);

    logic [XLEN-1:0]   r_regs [N_REGS];
    logic [N_REGS-1:0] r_busy;

    logic              w_hit;
    logic              w_claim_hit;
    logic [XLEN-1:0]   w_fwd;

    // Writes are applied in ascending port order so the highest index lands last;
    // the claim is applied after the writes so a new producer keeps the register busy.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int unsigned k = 0; k < N_REGS; k++) begin
                r_regs[k] <= '0;
            end
            r_busy <= '0;
        end else begin
            for (int unsigned p = 0; p < N_WPORTS; p++) begin
                if (i_we[p] && (i_waddr[p] != '0)) begin
                    r_regs[i_waddr[p]] <= i_wdata[p];
                    r_busy[i_waddr[p]] <= 1'b0;
                end
            end
            if (i_claim && (i_claim_addr != '0)) begin
                r_busy[i_claim_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        o_rdata     = '0;
        o_busy      = '0;
        w_hit       = 1'b0;
        w_claim_hit = 1'b0;
        w_fwd       = '0;
        for (int unsigned r = 0; r < N_RPORTS; r++) begin
            w_hit       = 1'b0;
            w_fwd       = '0;
            w_claim_hit = i_claim && (i_claim_addr == i_raddr[r]);
            for (int unsigned p = 0; p < N_WPORTS; p++) begin
                if (i_we[p] && (i_waddr[p] == i_raddr[r])) begin
                    w_hit = 1'b1;
                    w_fwd = i_wdata[p];
                end
            end
            // Outputs are forced quiet during reset, which also masks bypassed write data.
            if (i_rst || (i_raddr[r] == AW'(0))) begin
                o_rdata[r] = '0;
                o_busy[r]  = 1'b0;
            end else begin
                if ((BYPASS != 0) && w_hit) begin
                    o_rdata[r] = w_fwd;
                end else begin
                    o_rdata[r] = r_regs[i_raddr[r]];
                end
                o_busy[r] = r_busy[i_raddr[r]] && !((BYPASS != 0) && w_hit && !w_claim_hit);
            end
        end
    end

endmodule
